// File: rtl/ehgu_seq_checker.sv
// Stream consumer that checks accepted beats form an arithmetic progression of STEP.
// Optional random read throttling is enabled by defining EHGU_SEQ_CHECKER_THROTTLE_EN.
module ehgu_seq_checker #(
   parameter int WIDTH     = 8,
   parameter int STEP      = 3,
   parameter int NUM_BEATS = 200,
   parameter int CWIDTH    = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   input  logic [WIDTH-1:0]  din,
   input  logic              din_valid,
   output logic              en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CWIDTH-1:0] pass_cnt,
   output logic [CWIDTH-1:0] fail_cnt,
   output logic [WIDTH-1:0]  first_exp,
   output logic [WIDTH-1:0]  first_got
);

   localparam int              BW     = $clog2(NUM_BEATS + 1);
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam logic [BW-1:0]    LAST_W = BW'(NUM_BEATS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CHECK, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  exp_val;
   logic [WIDTH-1:0]  din_step;
   logic [BW-1:0]     beat_cnt;
   logic              beat_acc;
   logic              last_beat;
   logic              run_nxt;
   logic              thr;

   function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
      return (&v) ? v : v + CWIDTH'(1);
   endfunction

   // A beat landing in the same cycle as start or abort is dropped.
   assign beat_acc  = din_valid && en && !start && !abort;
   assign last_beat = (state == S_CHECK) && beat_acc && (beat_cnt == LAST_W);
   assign din_step  = din + STEP_W;
   assign busy      = (state == S_SYNC) || (state == S_CHECK);
   assign done      = (state == S_DONE);

`ifdef EHGU_SEQ_CHECKER_THROTTLE_EN
   logic [15:0] lfsr, lfsr_nxt;

   always_comb begin
      lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (start) lfsr_nxt = 16'hACE1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) lfsr <= 16'hACE1;
      else       lfsr <= lfsr_nxt;
   end

   // en is registered, so it follows the LFSR value it will coexist with.
   assign thr = lfsr_nxt[0] | lfsr_nxt[1];
`else
   assign thr = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_SYNC;
      end else begin
         case (state)
            S_SYNC: begin
               if (abort)         state_nxt = S_IDLE;
               else if (beat_acc) state_nxt = S_CHECK;
            end
            S_CHECK: begin
               if (abort)          state_nxt = S_IDLE;
               else if (last_beat) state_nxt = S_DONE;
            end
            default: state_nxt = state;
         endcase
      end
   end

   assign run_nxt = (state_nxt == S_SYNC) || (state_nxt == S_CHECK);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         en    <= 1'b0;
      end else begin
         state <= state_nxt;
         en    <= run_nxt && thr;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         err       <= 1'b0;
         first_exp <= '0;
         first_got <= '0;
         exp_val   <= '0;
         beat_cnt  <= '0;
      end else if (start) begin
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         err       <= 1'b0;
         first_exp <= '0;
         first_got <= '0;
         beat_cnt  <= '0;
      end else if (beat_acc && state == S_SYNC) begin
         exp_val <= din_step;
      end else if (beat_acc && state == S_CHECK) begin
         // Resync to received data so a single bad beat costs at most two fails.
         exp_val  <= din_step;
         beat_cnt <= beat_cnt + BW'(1);
         if (din == exp_val) begin
            pass_cnt <= sat_inc(pass_cnt);
         end else begin
            fail_cnt <= sat_inc(fail_cnt);
            err      <= 1'b1;
            if (!err) begin
               first_exp <= exp_val;
               first_got <= din;
            end
         end
      end
   end

endmodule
